// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    typedef logic [31:0] t_data;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_FETCH   = 2'd1,
        FETCH_DISCARD = 2'd2
    } t_fetch_state;

    localparam t_data INSTRUCTION_BYTES = 32'd4;
    localparam t_data PC_ALIGN_MASK     = 32'h0000_0003;

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter: loads a word-aligned redirect target or advances by one instruction.
module pc_register
    import fetch_unit_pkg::*;
#(
    parameter t_data RESET_VECTOR = 32'h0000_0000
) (
    input  logic  i_clk,
    input  logic  i_reset_n,
    input  logic  i_load,
    input  t_data i_load_value,
    input  logic  i_advance,
    output t_data o_pc
);

    t_data pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (i_load) begin
            pc_d = i_load_value & ~PC_ALIGN_MASK;
        end else if (i_advance) begin
            pc_d = pc_q + INSTRUCTION_BYTES;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues word-aligned memory requests, buffers one instruction for decode,
// and drops wrong-path responses after a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter t_data RESET_VECTOR = 32'h0000_0000
) (
    input  logic  i_clk,
    input  logic  i_reset_n,
    output logic  o_imem_req,
    output t_data o_imem_addr,
    input  logic  i_imem_ready,
    input  t_data i_imem_rdata,
    input  logic  i_redirect,
    input  t_data i_redirect_target,
    output logic  o_valid,
    input  logic  i_ready,
    output t_data o_instruction,
    output t_data o_pc
);

    t_fetch_state state_q, state_d;
    logic         valid_q, valid_d;
    t_data        instr_q, instr_d;
    t_data        pc_q, pc_d;
    t_data        discard_addr_q, discard_addr_d;
    t_data        fetch_pc;
    logic         pc_advance;
    logic         issue;
    logic         accept;

    pc_register #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_register (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_load       (i_redirect),
        .i_load_value (i_redirect_target),
        .i_advance    (pc_advance),
        .o_pc         (fetch_pc)
    );

    // Once raised in FETCH the request holds: an unaccepted request leaves the buffer empty.
    always_comb begin
        issue = 1'b0;
        case (state_q)
            FETCH_FETCH:   issue = !valid_q || i_ready;
            FETCH_DISCARD: issue = 1'b1;
            default:       issue = 1'b0;
        endcase
    end

    assign accept      = issue && i_imem_ready;
    assign o_imem_req  = issue;
    // The PC already points at the redirect target, so the stranded request keeps its own address.
    assign o_imem_addr = (state_q == FETCH_DISCARD) ? discard_addr_q : fetch_pc;

    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        instr_d        = instr_q;
        pc_d           = pc_q;
        discard_addr_d = discard_addr_q;
        pc_advance     = 1'b0;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_FETCH;
            end
            FETCH_FETCH: begin
                if (i_redirect) begin
                    if (issue && !i_imem_ready) begin
                        state_d        = FETCH_DISCARD;
                        discard_addr_d = fetch_pc;
                    end
                end else if (accept) begin
                    valid_d    = 1'b1;
                    instr_d    = i_imem_rdata;
                    pc_d       = fetch_pc;
                    pc_advance = 1'b1;
                end
            end
            FETCH_DISCARD: begin
                if (i_imem_ready) begin
                    state_d = FETCH_FETCH;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase

        if (i_redirect) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= FETCH_IDLE;
            valid_q        <= 1'b0;
            instr_q        <= '0;
            pc_q           <= '0;
            discard_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            instr_q        <= instr_d;
            pc_q           <= pc_d;
            discard_addr_q <= discard_addr_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_instruction = instr_q;
    assign o_pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: default reset vector plus a near-wrap reset vector instance.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam t_data MEM_KEY = 32'hA5A5_0000;
    localparam t_data HI_VEC  = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  reset_n, imem_ready, redirect, ready;
    t_data redirect_target;
    logic  imem_req, valid;
    t_data imem_addr, imem_rdata, instruction, pc;

    logic  h_reset_n, h_imem_ready, h_redirect, h_ready;
    t_data h_redirect_target;
    logic  h_imem_req, h_valid;
    t_data h_imem_addr, h_imem_rdata, h_instruction, h_pc;

    // Memory model: each word reads back as its address xor a key.
    assign imem_rdata   = imem_addr ^ MEM_KEY;
    assign h_imem_rdata = h_imem_addr ^ MEM_KEY;

    fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_ready(imem_ready), .i_imem_rdata(imem_rdata),
        .i_redirect(redirect), .i_redirect_target(redirect_target),
        .o_valid(valid), .i_ready(ready),
        .o_instruction(instruction), .o_pc(pc)
    );

    fetch_unit #(.RESET_VECTOR(HI_VEC)) dut_hi (
        .i_clk(clk), .i_reset_n(h_reset_n),
        .o_imem_req(h_imem_req), .o_imem_addr(h_imem_addr),
        .i_imem_ready(h_imem_ready), .i_imem_rdata(h_imem_rdata),
        .i_redirect(h_redirect), .i_redirect_target(h_redirect_target),
        .o_valid(h_valid), .i_ready(h_ready),
        .o_instruction(h_instruction), .o_pc(h_pc)
    );

    int    checks = 0;
    int    errors = 0;
    t_data exp_q[$];

    // Pops the scoreboard on every decode handshake, then advances one cycle.
    task automatic tick();
        t_data e;
        if (valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out o_pc=%h required=no_instruction", pc);
            end else begin
                e = exp_q.pop_front();
                if (pc !== e) begin
                    errors++;
                    $display("FAIL out_pc actual=%h required=%h", pc, e);
                end
                checks++;
                if (instruction !== (e ^ MEM_KEY)) begin
                    errors++;
                    $display("FAIL out_instr actual=%h required=%h", instruction, e ^ MEM_KEY);
                end
                $display("consumed pc=%h instr=%h", pc, instruction);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_hi();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl valid=%b req=%b required=0,0", valid, imem_req);
        end
        checks++;
        if (instruction !== 32'h0 || pc !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data instr=%h pc=%h addr=%h required=0,0,0", instruction, pc, imem_addr);
        end
        reset_n    = 1'b1;
        imem_ready = 1'b1;
        ready      = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_req actual=%b required=0", imem_req);
        end
        tick();
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(t_data'(4 * k));
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== t_data'(4 * k)) begin
                errors++;
                $display("FAIL stream_req req=%b addr=%h required=1,%h", imem_req, imem_addr, t_data'(4 * k));
            end
            tick();
        end
    endtask

    task automatic test_hold();
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (valid !== 1'b1 || pc !== 32'h8 || instruction !== (32'h8 ^ MEM_KEY) || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL hold valid=%b pc=%h instr=%h req=%b required=1,8,%h,0",
                         valid, pc, instruction, imem_req, 32'h8 ^ MEM_KEY);
            end
            tick();
        end
        ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            errors++;
            $display("FAIL hold_release req=%b addr=%h required=1,c", imem_req, imem_addr);
        end
        exp_q.push_back(32'hC);
        tick();
    endtask

    task automatic test_redirect_stall();
        imem_ready = 1'b0;
        for (int s = 1; s <= 5; s++) begin
            redirect        = (s == 2);
            redirect_target = 32'h103;
            imem_ready      = (s == 5);
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
                errors++;
                $display("FAIL stall_req s=%0d req=%b addr=%h required=1,10", s, imem_req, imem_addr);
            end
            tick();
        end
        redirect = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL stall_target valid=%b req=%b addr=%h required=0,1,100", valid, imem_req, imem_addr);
        end
        exp_q.push_back(32'h100);
        tick();
    endtask

    task automatic test_same_cycle_redirect();
        redirect        = 1'b1;
        redirect_target = 32'h1C;
        #1;
        tick();
        redirect = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || imem_addr !== 32'h1C) begin
            errors++;
            $display("FAIL setup_redirect valid=%b addr=%h required=0,1c", valid, imem_addr);
        end
        exp_q.push_back(32'h1C);
        tick();
        redirect        = 1'b1;
        redirect_target = 32'h40;
        #1;
        checks++;
        if (valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin
            errors++;
            $display("FAIL same_cycle_pre valid=%b req=%b addr=%h required=1,1,20", valid, imem_req, imem_addr);
        end
        tick();
        redirect = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL same_cycle_post valid=%b addr=%h required=0,40", valid, imem_addr);
        end
        exp_q.push_back(32'h40);
        tick();
    endtask

    task automatic test_double_redirect();
        imem_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            redirect        = (s == 1) || (s == 2);
            redirect_target = (s == 1) ? 32'h200 : 32'h300;
            imem_ready      = (s == 3);
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin
                errors++;
                $display("FAIL discard_req s=%0d req=%b addr=%h required=1,44", s, imem_req, imem_addr);
            end
            tick();
        end
        redirect = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL last_redirect valid=%b addr=%h required=0,300", valid, imem_addr);
        end
        exp_q.push_back(32'h300);
        tick();
        imem_ready = 1'b0;
        #1;
        tick();
        #1;
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_wrap_reset();
        t_data a;
        h_reset_n    = 1'b1;
        h_imem_ready = 1'b1;
        h_ready      = 1'b1;
        #1;
        checks++;
        if (h_imem_req !== 1'b0 || h_imem_addr !== HI_VEC) begin
            errors++;
            $display("FAIL hi_idle req=%b addr=%h required=0,%h", h_imem_req, h_imem_addr, HI_VEC);
        end
        step_hi();
        for (int k = 0; k < 3; k++) begin
            a = t_data'(HI_VEC + 4 * k);
            #1;
            checks++;
            if (h_imem_req !== 1'b1 || h_imem_addr !== a) begin
                errors++;
                $display("FAIL hi_wrap_req k=%0d req=%b addr=%h required=1,%h", k, h_imem_req, h_imem_addr, a);
            end
            if (k > 0) begin
                checks++;
                if (h_valid !== 1'b1 || h_pc !== a - 32'd4 || h_instruction !== ((a - 32'd4) ^ MEM_KEY)) begin
                    errors++;
                    $display("FAIL hi_wrap_out valid=%b pc=%h required=1,%h", h_valid, h_pc, a - 32'd4);
                end
            end
            $display("hi fetch addr=%h", h_imem_addr);
            step_hi();
        end
        h_imem_ready = 1'b0;
        #1;
        checks++;
        if (h_valid !== 1'b1 || h_pc !== 32'h0 || h_imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL hi_wrap_zero valid=%b pc=%h addr=%h required=1,0,4", h_valid, h_pc, h_imem_addr);
        end
        step_hi();
        #2;
        h_reset_n = 1'b0;
        #1;
        checks++;
        if (h_valid !== 1'b0 || h_imem_req !== 1'b0 || h_imem_addr !== HI_VEC) begin
            errors++;
            $display("FAIL hi_async_reset valid=%b req=%b addr=%h required=0,0,%h",
                     h_valid, h_imem_req, h_imem_addr, HI_VEC);
        end
        @(negedge clk);
        h_reset_n    = 1'b1;
        h_imem_ready = 1'b1;
        step_hi();
        #1;
        checks++;
        if (h_imem_req !== 1'b1 || h_imem_addr !== HI_VEC) begin
            errors++;
            $display("FAIL hi_refetch req=%b addr=%h required=1,%h", h_imem_req, h_imem_addr, HI_VEC);
        end
        step_hi();
        #1;
        checks++;
        if (h_valid !== 1'b1 || h_pc !== HI_VEC) begin
            errors++;
            $display("FAIL hi_refetch_out valid=%b pc=%h required=1,%h", h_valid, h_pc, HI_VEC);
        end
    endtask

    initial begin
        reset_n           = 1'b0;
        imem_ready        = 1'b0;
        redirect          = 1'b0;
        redirect_target   = '0;
        ready             = 1'b0;
        h_reset_n         = 1'b0;
        h_imem_ready      = 1'b0;
        h_redirect        = 1'b0;
        h_redirect_target = '0;
        h_ready           = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_stream();
        test_hold();
        test_redirect_stall();
        test_same_cycle_redirect();
        test_double_redirect();
        @(negedge clk);
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
